// File: rtl/auto_ta_pkg.sv
// Shared types and constants for the multi-channel auto threshold scan engine.
// Result words carry a 4-bit tag in the top nibble so the readout can parse the stream.
package auto_ta_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_SET_SC,
    S_WAIT_SC,
    S_COUNT,
    S_WRITE,
    S_NEXT,
    S_TAIL,
    S_DONE
  } state_t;

  localparam logic [3:0]  TAG_CH     = 4'hC;
  localparam logic [3:0]  TAG_DAC    = 4'hD;
  localparam logic [3:0]  TAG_CNT    = 4'hE;
  localparam logic [15:0] END_WORD   = 16'hF000;
  localparam logic [15:0] ABORT_WORD = 16'hFAAA;
  localparam logic [15:0] TOUT_WORD  = 16'hFEEE;

endpackage

// File: rtl/ta_hit_counter.sv
// Synchronises trigger and hit, opens a hit window after each trigger edge and
// counts triggers plus at most one hit per trigger window.
module ta_hit_counter #(
  parameter int N_TRIG  = 100,
  parameter int HIT_WIN = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic        trig,
  input  logic        hit,
  output logic [11:0] trig_cnt,
  output logic [11:0] hit_cnt,
  output logic        done
);

  localparam int WIN_W = $clog2(HIT_WIN + 1);

  logic             trig_meta, trig_s, trig_d;
  logic             hit_meta, hit_s;
  logic [WIN_W-1:0] win_cnt;
  logic             hit_taken;
  logic             trig_rise;

  assign trig_rise = trig_s & ~trig_d;
  assign done      = (trig_cnt == 12'(N_TRIG)) && (win_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_meta <= 1'b0;
      trig_s    <= 1'b0;
      trig_d    <= 1'b0;
      hit_meta  <= 1'b0;
      hit_s     <= 1'b0;
      win_cnt   <= '0;
      hit_taken <= 1'b0;
      trig_cnt  <= '0;
      hit_cnt   <= '0;
    end else begin
      trig_meta <= trig;
      trig_s    <= trig_meta;
      trig_d    <= trig_s;
      hit_meta  <= hit;
      hit_s     <= hit_meta;
      if (clear) begin
        win_cnt   <= '0;
        hit_taken <= 1'b0;
        trig_cnt  <= '0;
        hit_cnt   <= '0;
      end else if (enable) begin
        // A new edge restarts the window; edges past N_TRIG are ignored.
        if (trig_rise && (trig_cnt != 12'(N_TRIG))) begin
          trig_cnt  <= trig_cnt + 12'd1;
          win_cnt   <= WIN_W'(HIT_WIN);
          hit_taken <= 1'b0;
        end else if (win_cnt != '0) begin
          win_cnt <= win_cnt - WIN_W'(1);
          if (hit_s && !hit_taken) begin
            hit_cnt   <= hit_cnt + 12'd1;
            hit_taken <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/auto_ta_scan_multi.sv
// Auto threshold scan: per channel, sweep the DAC, reload SC, count hits over
// N_TRIG triggers and push tagged result words into the scan FIFO.
// FIFO handshake: a word transfers in every cycle where Out_Fifo_Wr=1, and Out_Fifo_Wr
// is only raised while In_Fifo_Full=0; Out_Fifo_Din is held stable while full.
module auto_ta_scan_multi
  import auto_ta_pkg::*;
#(
  parameter int N_CH       = 64,
  parameter int DAC_W      = 10,
  parameter int N_TRIG     = 100,
  parameter int SC_TIMEOUT = 100000,
  parameter int HIT_WIN    = 20
) (
  input  logic              Clk_10MHz,
  input  logic              Rst,
  input  logic              In_Start_Scan,
  input  logic              In_Abort,
  input  logic [DAC_W-1:0]  In_Ini_DAC,
  input  logic [DAC_W-1:0]  In_End_DAC,
  input  logic [DAC_W-1:0]  In_Step,
  input  logic              In_Early_Stop,
  input  logic              In_Trig_Ex_From_Signal,
  input  logic              In_Hit_From_SKIROC,
  input  logic              In_Finish_Sc,
  input  logic              In_Fifo_Full,
  output logic              Out_Set_SC,
  output logic [DAC_W-1:0]  Out_Set_DAC,
  output logic [N_CH-1:0]   Out_Mask_Code,
  output logic [15:0]       Out_Fifo_Din,
  output logic              Out_Fifo_Wr,
  output logic              Out_Busy,
  output logic              Out_Finish_Scan,
  output logic              Out_Error,
  output state_t            Out_Dbg_State
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TO_W = $clog2(SC_TIMEOUT + 1);

  state_t            state, state_next;
  logic              start_d, start_rise;
  logic [CH_W-1:0]   ch;
  logic [DAC_W-1:0]  dac, ini_dac, end_dac, step;
  logic              early;
  logic [TO_W-1:0]   tout_cnt;
  logic [1:0]        word_idx;
  logic [15:0]       tail_word;
  logic              err;
  logic [DAC_W:0]    nd;
  logic              adv_ch, last_ch, tout_hit, in_scan, abort_go;
  logic [11:0]       trig_cnt, hit_cnt;
  logic              cnt_done;

  ta_hit_counter #(.N_TRIG(N_TRIG), .HIT_WIN(HIT_WIN)) u_hit_counter (
    .clk      (Clk_10MHz),
    .rst      (Rst),
    .clear    ((state == S_WAIT_SC) && In_Finish_Sc),
    .enable   (state == S_COUNT),
    .trig     (In_Trig_Ex_From_Signal),
    .hit      (In_Hit_From_SKIROC),
    .trig_cnt (trig_cnt),
    .hit_cnt  (hit_cnt),
    .done     (cnt_done)
  );

  assign start_rise = In_Start_Scan & ~start_d;
  assign nd         = {1'b0, dac} + {1'b0, step};
  // Wide compare covers both "past end" and carry-out of the DAC range.
  assign adv_ch     = (nd > {1'b0, end_dac}) || (early && (hit_cnt == 12'd0));
  assign last_ch    = (ch == CH_W'(N_CH - 1));
  assign tout_hit   = (tout_cnt == TO_W'(SC_TIMEOUT - 1));
  assign in_scan    = (state == S_LOAD) || (state == S_SET_SC) || (state == S_WAIT_SC) ||
                      (state == S_COUNT) || (state == S_WRITE) || (state == S_NEXT);
  assign abort_go   = In_Abort && in_scan;

  always_ff @(posedge Clk_10MHz) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start_rise) state_next = S_LOAD;
      S_LOAD:    state_next = S_SET_SC;
      S_SET_SC:  state_next = S_WAIT_SC;
      S_WAIT_SC: if (In_Finish_Sc) state_next = S_COUNT;
                 else if (tout_hit) state_next = S_TAIL;
      S_COUNT:   if (cnt_done) state_next = S_WRITE;
      S_WRITE:   if (!In_Fifo_Full && (word_idx == 2'd2)) state_next = S_NEXT;
      S_NEXT:    state_next = (adv_ch && last_ch) ? S_TAIL : S_LOAD;
      S_TAIL:    if (!In_Fifo_Full) state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
    if (abort_go) state_next = S_TAIL;
  end

  always_ff @(posedge Clk_10MHz) begin
    if (Rst) begin
      start_d   <= 1'b0;
      ch        <= '0;
      dac       <= '0;
      ini_dac   <= '0;
      end_dac   <= '0;
      step      <= '0;
      early     <= 1'b0;
      tout_cnt  <= '0;
      word_idx  <= '0;
      tail_word <= '0;
      err       <= 1'b0;
    end else begin
      start_d <= In_Start_Scan;
      case (state)
        S_IDLE: if (start_rise) begin
          ini_dac <= In_Ini_DAC;
          end_dac <= In_End_DAC;
          step    <= (In_Step == '0) ? DAC_W'(1) : In_Step;
          early   <= In_Early_Stop;
          ch      <= '0;
          dac     <= In_Ini_DAC;
          err     <= 1'b0;
        end
        S_SET_SC:  tout_cnt <= '0;
        S_WAIT_SC: begin
          tout_cnt <= tout_cnt + TO_W'(1);
          if (!In_Finish_Sc && tout_hit && !In_Abort) begin
            err       <= 1'b1;
            tail_word <= TOUT_WORD;
          end
        end
        S_COUNT:   word_idx <= '0;
        S_WRITE:   if (!In_Fifo_Full) word_idx <= word_idx + 2'd1;
        S_NEXT: begin
          if (!adv_ch) begin
            dac <= nd[DAC_W-1:0];
          end else if (!last_ch) begin
            ch  <= ch + CH_W'(1);
            dac <= ini_dac;
          end else begin
            tail_word <= END_WORD;
          end
        end
        default: ;
      endcase
      if (abort_go) tail_word <= ABORT_WORD;
    end
  end

  always_comb begin
    Out_Set_SC      = (state == S_SET_SC);
    Out_Set_DAC     = dac;
    Out_Mask_Code   = '1;
    if (in_scan) Out_Mask_Code[ch] = 1'b0;
    Out_Fifo_Din    = 16'h0000;
    case (state)
      S_WRITE: begin
        case (word_idx)
          2'd0:    Out_Fifo_Din = {TAG_CH, 12'(ch)};
          2'd1:    Out_Fifo_Din = {TAG_DAC, 12'(dac)};
          default: Out_Fifo_Din = {TAG_CNT, hit_cnt};
        endcase
      end
      S_TAIL:  Out_Fifo_Din = tail_word;
      default: ;
    endcase
    // A result word is dropped in the cycle abort wins; the abort word follows.
    Out_Fifo_Wr     = (((state == S_WRITE) && !In_Abort) || (state == S_TAIL)) && !In_Fifo_Full;
    Out_Busy        = (state != S_IDLE);
    Out_Finish_Scan = (state == S_DONE);
    Out_Error       = err;
    Out_Dbg_State   = state;
  end

endmodule

// File: tb/tb_auto_ta_scan_multi.sv
// Scoreboard bench for auto_ta_scan_multi: expected FIFO words are queued when a
// scan is launched and compared as the DUT writes them.
module tb_auto_ta_scan_multi;
  import auto_ta_pkg::*;

  localparam int N_CH = 2, DAC_W = 10, N_TRIG = 4, SC_TIMEOUT = 50, HIT_WIN = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0, abort = 1'b0, early = 1'b0;
  logic [DAC_W-1:0]  ini = '0, end_dac = '0, step = '0;
  logic              trig = 1'b0, hit = 1'b0, fin_sc = 1'b0, full = 1'b0;
  logic              set_sc, fifo_wr, busy, finish, error;
  logic [DAC_W-1:0]  set_dac;
  logic [N_CH-1:0]   mask;
  logic [15:0]       din;
  state_t            dbg_state;

  logic [15:0] exp_q[$];
  int n_checks = 0, n_fail = 0;
  int cyc = 0, fin_cnt = 0, setsc_cyc = 0, wr_cyc = 0;
  int hit_mode = 0;
  bit sc_enable = 1'b1;
  int sc_delay = 5;

  auto_ta_scan_multi #(.N_CH(N_CH), .DAC_W(DAC_W), .N_TRIG(N_TRIG),
                       .SC_TIMEOUT(SC_TIMEOUT), .HIT_WIN(HIT_WIN)) dut (
    .Clk_10MHz              (clk),
    .Rst                    (rst),
    .In_Start_Scan          (start),
    .In_Abort               (abort),
    .In_Ini_DAC             (ini),
    .In_End_DAC             (end_dac),
    .In_Step                (step),
    .In_Early_Stop          (early),
    .In_Trig_Ex_From_Signal (trig),
    .In_Hit_From_SKIROC     (hit),
    .In_Finish_Sc           (fin_sc),
    .In_Fifo_Full           (full),
    .Out_Set_SC             (set_sc),
    .Out_Set_DAC            (set_dac),
    .Out_Mask_Code          (mask),
    .Out_Fifo_Din           (din),
    .Out_Fifo_Wr            (fifo_wr),
    .Out_Busy               (busy),
    .Out_Finish_Scan        (finish),
    .Out_Error              (error),
    .Out_Dbg_State          (dbg_state)
  );

  // clock / reset
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard / monitor on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (finish) fin_cnt++;
      if (set_sc) setsc_cyc = cyc;
      if (fifo_wr) begin
        wr_cyc = cyc;
        if (exp_q.size() == 0) check("fifo_extra_word", exp_q.size(), 1);
        else check("fifo_word", din, exp_q.pop_front());
      end
    end
  end

  // free-running external trigger: 3 high, 9 low
  initial begin
    int phase = 0;
    forever begin
      @(posedge clk); #1;
      phase = (phase == 11) ? 0 : phase + 1;
      trig = (phase < 3);
    end
  end

  // hit source follows the programmed DAC
  initial begin
    forever begin
      @(posedge clk); #1;
      hit = (hit_mode == 0) || ((hit_mode == 1) && (set_dac < 10'd11));
    end
  end

  // slow-control model answers each load request after sc_delay cycles
  initial begin
    forever begin
      @(negedge clk);
      if (set_sc && sc_enable) begin
        repeat (sc_delay) @(posedge clk);
        #1 fin_sc = 1'b1;
        @(posedge clk); #1 fin_sc = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic start_scan(input int i, input int e, input int s, input bit es);
    ini = DAC_W'(i); end_dac = DAC_W'(e); step = DAC_W'(s); early = es;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin @(posedge clk); #1; n++; end
    check("busy_drop", busy, 0);
    @(negedge clk);
  endtask

  task automatic wait_state(input state_t s, input int budget, input string tag);
    int n = 0;
    while (dbg_state != s && n < budget) begin @(posedge clk); #1; n++; end
    check(tag, 32'(dbg_state), 32'(s));
  endtask

  task automatic push_point(input int c, input int d, input int h);
    exp_q.push_back({TAG_CH, 12'(c)});
    exp_q.push_back({TAG_DAC, 12'(d)});
    exp_q.push_back({TAG_CNT, 12'(h)});
  endtask

  task automatic end_of_scan(input int fin0, input string tag);
    check({tag, "_finish_pulses"}, fin_cnt - fin0, 1);
    check({tag, "_q_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int fin0, gap;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_mask", mask, 2'b11);
    check("rst_wr", fifo_wr, 0);
    check("rst_setsc", set_sc, 0);
    check("rst_dac", set_dac, 0);
    check("rst_din", din, 0);
    check("rst_finish", finish, 0);
    check("rst_error", error, 0);

    // basic sweep, hits on every trigger
    fin0 = fin_cnt; hit_mode = 0;
    for (int c = 0; c < N_CH; c++) for (int d = 10; d <= 12; d++) push_point(c, d, N_TRIG);
    exp_q.push_back(END_WORD);
    start_scan(10, 12, 1, 1'b0);
    wait_idle(2000);
    end_of_scan(fin0, "sweep");

    // early stop: hits only below 11
    fin0 = fin_cnt; hit_mode = 1;
    for (int c = 0; c < N_CH; c++) begin push_point(c, 10, N_TRIG); push_point(c, 11, 0); end
    exp_q.push_back(END_WORD);
    start_scan(10, 20, 1, 1'b1);
    wait_idle(2000);
    end_of_scan(fin0, "early");

    // SC timeout
    fin0 = fin_cnt; sc_enable = 1'b0;
    exp_q.push_back(TOUT_WORD);
    start_scan(10, 12, 1, 1'b0);
    wait_idle(500);
    gap = wr_cyc - setsc_cyc;
    check("tout_latency_50_52", (gap >= 50 && gap <= 52), 1);
    check("tout_error", error, 1);
    end_of_scan(fin0, "tout");
    sc_enable = 1'b1;

    // back-pressure during WRITE, step 0 behaves as 1
    fin0 = fin_cnt; hit_mode = 0;
    for (int c = 0; c < N_CH; c++) for (int d = 10; d <= 12; d++) push_point(c, d, N_TRIG);
    exp_q.push_back(END_WORD);
    start_scan(10, 12, 0, 1'b0);
    check("start_clears_error", error, 0);
    wait_state(S_WRITE, 500, "reach_write");
    full = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); check("no_wr_while_full", fifo_wr, 0);
      @(posedge clk); #1;
    end
    full = 1'b0;
    wait_idle(2000);
    end_of_scan(fin0, "full");

    // ini above end: one point per channel
    fin0 = fin_cnt;
    for (int c = 0; c < N_CH; c++) push_point(c, 20, N_TRIG);
    exp_q.push_back(END_WORD);
    start_scan(20, 5, 1, 1'b0);
    wait_idle(1000);
    end_of_scan(fin0, "ini_gt_end");

    // abort during COUNT
    fin0 = fin_cnt;
    exp_q.push_back(ABORT_WORD);
    start_scan(10, 12, 1, 1'b0);
    wait_state(S_COUNT, 200, "reach_count");
    @(negedge clk); check("count_mask", mask, 2'b10);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_idle(5);
    check("abort_mask", mask, 2'b11);
    end_of_scan(fin0, "abort");

    // reset mid-scan, second start while busy
    fin0 = fin_cnt; sc_enable = 1'b0;
    start_scan(10, 12, 1, 1'b0);
    wait_state(S_WAIT_SC, 20, "reach_wait_sc");
    start = 1'b1;
    @(posedge clk); #1;
    check("busy_start_ignored", 32'(dbg_state), 32'(S_WAIT_SC));
    start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_mask", mask, 2'b11);
    check("midrst_dac", set_dac, 0);
    check("midrst_wr", fifo_wr, 0);
    repeat (10) @(negedge clk);
    check("midrst_stays_idle", busy, 0);
    check("midrst_no_finish", fin_cnt - fin0, 0);
    check("midrst_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/auto_ta_scan_multi.md
Name: auto_ta_scan_multi

Overview:
- Parametrised successor to the single-DAC auto threshold (TA) scan engine in the ECAL DIF.
- Sequentially unmasks one channel at a time and sweeps its discriminator DAC from a start value to an end value in programmable steps.
- At each DAC point it requests a slow-control (SC) reload, counts hits over a fixed number of external triggers, and writes tagged 16-bit result words to the downstream scan FIFO.
- Adds over the previous generation: channel-count, DAC-width and trigger-count generics; programmable step and end point; early stop; SC timeout; FIFO back-pressure; abort.

Parameters:
- N_CH, 64, number of channels scanned; 1..256.
- DAC_W, 10, DAC code width; at most 12.
- N_TRIG, 100, triggers per DAC point; 1..4095.
- SC_TIMEOUT, 100000, cycles to wait for In_Finish_Sc before declaring an error.
- HIT_WIN, 20, cycles after a trigger rising edge during which a hit is accepted.

Ports:
- Clk_10MHz  in  1  system clock.
- Rst  in  1  synchronous, active-high reset.
- In_Start_Scan  in  1  rising edge starts a scan; ignored unless IDLE.
- In_Abort  in  1  level; forces the abort sequence.
- In_Ini_DAC  in  DAC_W  start DAC code; sampled at start.
- In_End_DAC  in  DAC_W  last DAC code; sampled at start.
- In_Step  in  DAC_W  DAC increment; sampled at start; 0 is treated as 1.
- In_Early_Stop  in  1  if 1, a channel ends after the first DAC point with 0 hits; sampled at start.
- In_Trig_Ex_From_Signal  in  1  external trigger, rising-edge active, asynchronous.
- In_Hit_From_SKIROC  in  1  hit flag, level, asynchronous.
- In_Finish_Sc  in  1  SC load done; level of at least 1 cycle.
- In_Fifo_Full  in  1  downstream FIFO full.
- Out_Set_SC  out  1  one-cycle SC load request.
- Out_Set_DAC  out  DAC_W  current DAC code.
- Out_Mask_Code  out  N_CH  1 = masked; all ones except the active channel.
- Out_Fifo_Din  out  16  result word.
- Out_Fifo_Wr  out  1  write strobe.
- Out_Busy  out  1  high in any state other than IDLE.
- Out_Finish_Scan  out  1  one-cycle pulse at the end of a scan or abort.
- Out_Error  out  1  sticky SC-timeout flag; cleared at the next start.

Behaviour:
- Reset values: all outputs 0, except Out_Mask_Code = all ones; state IDLE.
- Synchronisers: trigger and hit each pass through a 2-FF synchroniser; trigger edge-detect follows the synchroniser. Start is edge-detected directly.
- IDLE -> LOAD on a start edge. Inputs are latched; ch = 0; dac = In_Ini_DAC; Out_Error cleared.
- LOAD (1 cycle):
  - drive Out_Set_DAC = dac and the mask with bit ch cleared;
  - next cycle, Out_Set_SC = 1 for one cycle;
  - go to WAIT_SC.
- WAIT_SC:
  - In_Finish_Sc = 1 -> COUNT; the trigger counter and hit counter are cleared.
  - Timeout counter reaches SC_TIMEOUT -> Out_Error = 1, write 16'hFEEE, go to DONE.
- COUNT:
  - Each synchronised trigger rising edge increments trig_cnt and opens a HIT_WIN window.
  - A synchronised hit that is high on any cycle in the window counts once per trigger.
  - A trigger edge arriving while a window is open closes the old window and opens a new one.
  - When trig_cnt = N_TRIG and the last window has closed -> WRITE.
- WRITE: emits 3 words in order, each written only in a cycle where In_Fifo_Full = 0. While full, Out_Fifo_Wr = 0 and Din is held.
  - {4'hC, ch[7:0] zero-extended to 12 bits}
  - {4'hD, dac zero-extended to 12 bits}
  - {4'hE, hit_cnt[11:0]}
- NEXT:
  - Compute nd = dac + step with DAC_W+1 bits.
  - If nd > end, or nd overflows, or (early stop is set and hit_cnt = 0) -> advance the channel.
  - Otherwise dac = nd -> LOAD.
  - Advancing: ch + 1; dac = In_Ini_DAC -> LOAD. If ch = N_CH-1 instead -> write end word 16'hF000 -> DONE.
  - If In_Ini_DAC > In_End_DAC, each channel gets exactly one point, at In_Ini_DAC.
- DONE: Out_Finish_Scan pulses for 1 cycle; mask returns to all ones; -> IDLE.
- Abort: in any non-IDLE state, In_Abort = 1 -> write 16'hFAAA (obeying full) -> DONE.
  - A partially written result triplet is abandoned.
  - Abort has priority over a simultaneous SC finish or trigger.
- A start edge while Busy is ignored.
- Rst mid-scan returns everything to reset values on the next clock edge; no FIFO word is emitted.

Decomposition:
- Package auto_ta_pkg holds:
  - the state enum;
  - tag constants TAG_CH = 4'hC, TAG_DAC = 4'hD, TAG_CNT = 4'hE;
  - words END_WORD = 16'hF000, ABORT_WORD = 16'hFAAA, TOUT_WORD = 16'hFEEE.
- One sub-module, ta_hit_counter, owns the trigger/hit synchronisers, the windowing and both counters. Ports: clear, enable, trig_cnt, hit_cnt, done.

Test Plan:
- N_CH=2, ini=10, end=12, step=1, hits on every trigger (N_TRIG=4), SC done after 5 cycles.
  -> 6 triplets: C000/D00A/E004 … C001/D00C/E004, then F000; one Finish pulse.
- Early stop on, hits only when dac < 11, ini=10, end=20.
  -> per channel, words for 10 (E004) and 11 (E000) only.
- In_Finish_Sc never asserted, SC_TIMEOUT=50.
  -> FEEE written about 51 cycles after Set_SC; Out_Error = 1; Finish pulse.
- In_Fifo_Full held for 10 cycles during WRITE.
  -> no Wr while full; words emitted unchanged and in order afterwards.
- In_Abort during COUNT.
  -> FAAA only; mask all ones; Busy = 0 two cycles later.
- Rst during WAIT_SC and a second start edge while Busy.
  -> outputs return to reset values; the second start has no effect.
